// File: rtl/simple_processor.sv
// 8-bit single-cycle accumulator core running a 16-word parameterised ROM.
// One instruction commits per rising edge; there is no host handshake.
module simple_processor #(
  parameter logic [127:0] PROGRAM = 128'h0000_0000_0000_0000_0000_D030_6011_4020
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDI = 4'h1, OP_IN  = 4'h2, OP_OUT = 4'h3,
    OP_MOV = 4'h4, OP_LDR = 4'h5, OP_ADD = 4'h6, OP_SUB = 4'h7,
    OP_AND = 4'h8, OP_OR  = 4'h9, OP_XOR = 4'hA, OP_SHL = 4'hB,
    OP_SHR = 4'hC, OP_JMP = 4'hD, OP_JZ  = 4'hE, OP_JC  = 4'hF
  } op_e;

  logic [3:0]      pc, pc_nxt;
  logic [7:0]      acc, acc_nxt;
  logic [3:0][7:0] regs;
  logic            z, c, z_nxt, c_nxt;
  logic [7:0]      instr;
  op_e             op;
  logic [1:0]      n;
  logic [3:0]      imm;
  logic [7:0]      rn;
  logic [8:0]      sum;
  logic            reg_we, out_we, z_upd;

  assign instr = PROGRAM[{pc, 3'b000} +: 8];
  assign op    = op_e'(instr[7:4]);
  assign n     = instr[1:0];
  assign imm   = instr[3:0];
  assign rn    = regs[n];
  assign sum   = {1'b0, acc} + {1'b0, rn};

  always_comb begin
    pc_nxt  = pc + 4'd1;
    acc_nxt = acc;
    c_nxt   = c;
    z_upd   = 1'b0;
    reg_we  = 1'b0;
    out_we  = 1'b0;
    case (op)
      OP_LDI: begin acc_nxt = {4'b0, imm};  z_upd = 1'b1; end
      OP_IN:  begin acc_nxt = data_in;      z_upd = 1'b1; end
      OP_OUT: out_we = 1'b1;
      OP_MOV: reg_we = 1'b1;
      OP_LDR: begin acc_nxt = rn;           z_upd = 1'b1; end
      OP_ADD: begin {c_nxt, acc_nxt} = sum; z_upd = 1'b1; end
      OP_SUB: begin
        acc_nxt = acc - rn;
        c_nxt   = (acc < rn);
        z_upd   = 1'b1;
      end
      OP_AND: begin acc_nxt = acc & rn;     z_upd = 1'b1; end
      OP_OR:  begin acc_nxt = acc | rn;     z_upd = 1'b1; end
      OP_XOR: begin acc_nxt = acc ^ rn;     z_upd = 1'b1; end
      OP_SHL: begin
        c_nxt   = acc[7];
        acc_nxt = {acc[6:0], 1'b0};
        z_upd   = 1'b1;
      end
      OP_SHR: begin
        c_nxt   = acc[0];
        acc_nxt = {1'b0, acc[7:1]};
        z_upd   = 1'b1;
      end
      // Conditional jumps look at the flags committed by the previous edge.
      OP_JMP: pc_nxt = imm;
      OP_JZ:  if (z) pc_nxt = imm;
      OP_JC:  if (c) pc_nxt = imm;
      default: ;
    endcase
    z_nxt = z_upd ? (acc_nxt == 8'h00) : z;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= '0;
      acc      <= '0;
      regs     <= '0;
      z        <= 1'b0;
      c        <= 1'b0;
      data_out <= '0;
    end else begin
      pc  <= pc_nxt;
      acc <= acc_nxt;
      z   <= z_nxt;
      c   <= c_nxt;
      if (reg_we) regs[n]  <= acc;
      if (out_we) data_out <= acc;
    end
  end

endmodule

// File: tb/tb_simple_processor.sv
// Directed bench: default echo program plus three custom ROM images
// (ALU/flag branches, logic ops with carry preservation, PC wrap).
module tb_simple_processor;

  logic            clk;
  logic            rst;
  logic [7:0]      echo_din, alu_din, logic_din, wrap_din;
  logic [3:0][7:0] dout;

  int checks = 0;
  int errors = 0;

  // LDI5 MOV1 LDI3 SUB1 JC6 JMP5 OUT LDI8 SHLx5 JZ15 JMP14 OUT
  localparam logic [127:0] ALU_PROG   = 128'h30DE_EFB0_B0B0_B0B0_1830_D5F6_7113_4115;
  // build R0=3C, C=1, then AND/OR/XOR against IN=F0, JC 4 loops back
  localparam logic [127:0] LOGIC_PROG = 128'hF430_A020_3090_2030_8020_B020_40B0_B01F;
  // IN, 14 NOPs, OUT at word 15
  localparam logic [127:0] WRAP_PROG  = 128'h3000_0000_0000_0000_0000_0000_0000_0020;

  simple_processor u_echo (.clk(clk), .rst(rst), .data_in(echo_din), .data_out(dout[0]));
  simple_processor #(.PROGRAM(ALU_PROG))   u_alu   (.clk(clk), .rst(rst), .data_in(alu_din),   .data_out(dout[1]));
  simple_processor #(.PROGRAM(LOGIC_PROG)) u_logic (.clk(clk), .rst(rst), .data_in(logic_din), .data_out(dout[2]));
  simple_processor #(.PROGRAM(WRAP_PROG))  u_wrap  (.clk(clk), .rst(rst), .data_in(wrap_din),  .data_out(dout[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } echo_t;

  typedef struct {
    int         e;
    int         dut;
    logic [7:0] exp;
  } seq_t;

  echo_t echo_vec [24];
  seq_t  seq_vec  [17];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // data_in per edge after release; IN at edges 1,7,13,19, OUT at 5,11,17,23
    echo_vec[0]  = '{8'h10, 8'h00}; echo_vec[1]  = '{8'h10, 8'h00};
    echo_vec[2]  = '{8'h10, 8'h00}; echo_vec[3]  = '{8'h10, 8'h00};
    echo_vec[4]  = '{8'h10, 8'h11}; echo_vec[5]  = '{8'h10, 8'h11};
    echo_vec[6]  = '{8'hFF, 8'h11}; echo_vec[7]  = '{8'h20, 8'h11};
    echo_vec[8]  = '{8'h30, 8'h11}; echo_vec[9]  = '{8'h40, 8'h11};
    echo_vec[10] = '{8'h50, 8'h00}; echo_vec[11] = '{8'h60, 8'h00};
    echo_vec[12] = '{8'h3A, 8'h00}; echo_vec[13] = '{8'h4B, 8'h00};
    echo_vec[14] = '{8'h5C, 8'h00}; echo_vec[15] = '{8'h6D, 8'h00};
    echo_vec[16] = '{8'h7E, 8'h3B}; echo_vec[17] = '{8'h8F, 8'h3B};
    echo_vec[18] = '{8'h01, 8'h3B}; echo_vec[19] = '{8'h02, 8'h3B};
    echo_vec[20] = '{8'h03, 8'h3B}; echo_vec[21] = '{8'h04, 8'h3B};
    echo_vec[22] = '{8'h05, 8'h02}; echo_vec[23] = '{8'h06, 8'h02};

    // ALU: JC taken -> OUT FE at edge 6; SHL 0x80 -> JZ taken -> OUT 00 at 14
    seq_vec[0]  = '{5,  1, 8'h00}; seq_vec[1]  = '{6,  1, 8'hFE};
    seq_vec[2]  = '{13, 1, 8'hFE}; seq_vec[3]  = '{14, 1, 8'h00};
    seq_vec[4]  = '{19, 1, 8'h00}; seq_vec[5]  = '{20, 1, 8'hFE};
    // logic: AND 30 @9, OR FC @12, XOR CC @15, JC taken -> AND again @21
    seq_vec[6]  = '{8,  2, 8'h00}; seq_vec[7]  = '{9,  2, 8'h30};
    seq_vec[8]  = '{11, 2, 8'h30}; seq_vec[9]  = '{12, 2, 8'hFC};
    seq_vec[10] = '{14, 2, 8'hFC}; seq_vec[11] = '{15, 2, 8'hCC};
    seq_vec[12] = '{20, 2, 8'hCC}; seq_vec[13] = '{21, 2, 8'h30};
    // wrap: OUT only at edges 16 and 32
    seq_vec[14] = '{15, 3, 8'h00}; seq_vec[15] = '{16, 3, 8'h21};
    seq_vec[16] = '{32, 3, 8'h42};

    alu_din   = 8'h00;
    logic_din = 8'hF0;
    wrap_din  = 8'h00;
    echo_din  = 8'h55;
    rst       = 1'b1;
    #1 rst    = 1'b0;
    #1;

    // reset held across edges
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reset_hold_%0d", i), dout[0], 8'h00);
    end

    // default echo, table driven
    rst = 1'b1;
    for (int i = 0; i < 24; i++) begin
      echo_din = echo_vec[i].din;
      step();
      chk($sformatf("echo_e%0d", i + 1), dout[0], echo_vec[i].exp);
    end

    // asynchronous clear between edges
    #3 rst = 1'b0;
    #1 chk("async_clear", dout[0], 8'h00);
    step();
    chk("reset_holds_across_edge", dout[0], 8'h00);

    // restart at PC=0 after release
    echo_din = 8'h7F;
    rst = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk($sformatf("restart_e%0d", e), dout[0], (e < 5) ? 8'h00 : 8'h80);
    end

    // custom-program sequences, all released together
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      wrap_din = (e == 1) ? 8'h21 : (e == 17) ? 8'h42 : 8'h99;
      step();
      for (int k = 0; k < 17; k++) begin
        if (seq_vec[k].e == e)
          chk($sformatf("prog%0d_e%0d", seq_vec[k].dut, e), dout[seq_vec[k].dut], seq_vec[k].exp);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simple_processor.md
Name: simple_processor

Overview:
- 8-bit single-cycle accumulator processor with an internal 16-word program ROM, set by parameter.
- Reads the external byte `data_in` through an IN instruction and drives `data_out` from an output register written by an OUT instruction.
- Used as a self-running compute core: after reset it executes its program continuously and needs no host handshake.

Parameters:
- PROGRAM, default 128'h0000_0000_0000_0000_0000_D030_6011_4020, ROM image; word i = PROGRAM[8*i+7 : 8*i]. The default program echoes data_in+1: IN; MOV R0; LDI 1; ADD R0; OUT; JMP 0.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- data_in  input  8  external operand, sampled by IN at the executing clock edge
- data_out  output  8  registered output port, updated only by OUT

Behaviour:
- State: PC[3:0], ACC[7:0], R0..R3[7:0], flags Z and C, data_out register.
- Reset (rst=0, asynchronous, no clock required): PC=0, ACC=0, R0..R3=0, Z=0, C=0, data_out=0. While rst=0, state holds.
- Execution: one instruction per rising edge, no pipeline. The instruction is ROM[PC], decoded combinationally, and all its effects are committed at that edge.
- Instruction format: op=[7:4]; n=[1:0] selects the register; imm/addr=[3:0].
- Sequencing: PC <= PC+1 mod 16 (15 wraps to 0) unless a taken jump loads addr.
- Opcodes:
  - 0 NOP: no state change except PC.
  - 1 LDI: ACC={4'b0,imm}.
  - 2 IN: ACC=data_in.
  - 3 OUT: data_out<=ACC. ACC and flags unchanged.
  - 4 MOV: R[n]=ACC. Flags unchanged.
  - 5 LDR: ACC=R[n].
  - 6 ADD: {C,ACC}=ACC+R[n] (9-bit sum).
  - 7 SUB: ACC=ACC-R[n] mod 256; C=1 if borrow (ACC<R[n]).
  - 8 AND, 9 OR, A XOR: ACC=ACC op R[n]. C unchanged.
  - B SHL: C=ACC[7], ACC={ACC[6:0],0}.
  - C SHR: C=ACC[0], ACC={0,ACC[7:1]}.
  - D JMP: PC=addr.
  - E JZ: PC=addr if Z=1, else PC+1.
  - F JC: PC=addr if C=1, else PC+1.
- Flags:
  - Z is updated to (new ACC==0) by opcodes 1,2,5,6,7,8,9,A,B,C. All others leave Z unchanged.
  - C is updated only by 6,7,B,C.
  - Jumps test the flags as they stood before the edge.
- data_out holds its value between OUT instructions and changes only at the edge executing OUT.
- Bits [3:2] are ignored for register-select opcodes. The operand field is ignored for NOP, IN, OUT, SHL, SHR.
- Reset asserted mid-program aborts the current instruction. After release, execution restarts at PC=0 on the first rising edge with rst=1.
- Unused ROM words are 0x00 (NOP), so a runaway PC wraps back to 0.
- Default program timing: the loop is 6 cycles. data_out = (data_in sampled at the IN edge + 1) mod 256, visible after the 5th edge of the iteration. 0xFF gives 0x00.

Test Plan:
- Reset: hold rst=0 for 3 cycles with clk toggling, data_in=0x55 -> data_out=0x00, no change. Assert rst=0 asynchronously between edges -> data_out clears immediately.
- Default echo: release reset, data_in=0x10 constant -> data_out=0x11 after edge 5. Then data_in=0xFF -> next loop outputs 0x00 (wrap).
- Latency/hold: change data_in every cycle -> data_out equals (value sampled at edges 1, 7, 13, …)+1, updates only at edges 5, 11, 17, …, and is stable in between.
- ALU/flags program (LDI 5; MOV R1; LDI 3; SUB R1; JC 7; OUT; JMP 6; OUT @7 …) -> SUB yields ACC=0xFE with C=1, the branch is taken, and data_out=0xFE. Also run a SHL of 0x80 -> ACC=0x00, C=1, Z=1, and JZ taken.
- Logic ops: ACC=0xF0, R0=0x3C -> AND 0x30, OR 0xFC, XOR 0xCC, each output via OUT. C must be unchanged across these ops.
- PC wrap: program of 15 NOPs then OUT at word 15 -> OUT executes every 16 cycles and PC returns to 0.
